// File: rtl/circular_shift_iterative_rotator_pkg.sv
`default_nettype none
// ============================================================================
// circular_shift_pkg : shared types for the iterative circular rotator
// Revision: 1.0
// ============================================================================
package circular_shift_pkg;

    typedef enum logic {
        DIR_LEFT  = 1'b0,
        DIR_RIGHT = 1'b1
    } rot_dir_t;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } rot_state_t;

endpackage
`default_nettype wire

// File: rtl/circular_shift_iterative_rotator_step.sv
`default_nettype none
// ============================================================================
// circular_rotate_by_one_step : combinational single-position rotate, L or R
// Revision: 1.0
// ============================================================================
module circular_rotate_by_one_step
    import circular_shift_pkg::*;
#(
    parameter int N = 8
) (
    input  logic [N-1:0] i_data,
    input  logic         i_dir,
    output logic [N-1:0] o_data
);

    assign o_data = (i_dir == DIR_RIGHT) ? {i_data[0], i_data[N-1:1]}
                                         : {i_data[N-2:0], i_data[N-1]};

endmodule
`default_nettype wire

// File: rtl/circular_shift_iterative_rotator.sv
`default_nettype none
// ============================================================================
// circular_shift_iterative_rotator : runtime-amount rotator, one bit per clock
// Revision: 1.0
// ============================================================================
module circular_shift_iterative_rotator
    import circular_shift_pkg::*;
#(
    parameter int N  = 8,
    parameter int AW = $clog2(N)
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic [N-1:0]  in_data,
    input  logic [AW-1:0] in_amt,
    input  logic          in_dir,
    output logic          out_valid,
    input  logic          out_ready,
    output logic [N-1:0]  out_data,
    output logic          busy
);

    localparam logic [31:0] c_n = 32'(N);

    rot_state_t    state_q, state_d;
    logic [N-1:0]  data_q,  data_d;
    logic [AW-1:0] cnt_q,   cnt_d;
    rot_dir_t      dir_q,   dir_d;

    logic [31:0]   w_amt_ext;
    logic [AW-1:0] w_amt_red;
    logic [N-1:0]  w_step;

    // in_amt < 2^AW < 2N, so a single conditional subtract is a full modulo
    assign w_amt_ext = 32'(in_amt);
    assign w_amt_red = (w_amt_ext >= c_n) ? AW'(w_amt_ext - c_n) : in_amt;

    circular_rotate_by_one_step #(
        .N(N)
    ) u_step (
        .i_data (data_q),
        .i_dir  (dir_q),
        .o_data (w_step)
    );

    always_comb begin
        state_d = state_q;
        data_d  = data_q;
        cnt_d   = cnt_q;
        dir_d   = dir_q;
        case (state_q)
            IDLE: begin
                if (in_valid) begin
                    data_d  = in_data;
                    cnt_d   = w_amt_red;
                    dir_d   = rot_dir_t'(in_dir);
                    state_d = (w_amt_red != '0) ? SHIFT : DONE;
                end
            end
            SHIFT: begin
                data_d = w_step;
                if (cnt_q != '0) begin
                    cnt_d = cnt_q - AW'(1);
                end
                if (cnt_q <= AW'(1)) begin
                    state_d = DONE;
                end
            end
            DONE: begin
                if (out_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            data_q  <= '0;
            cnt_q   <= '0;
            dir_q   <= DIR_LEFT;
        end else begin
            state_q <= state_d;
            data_q  <= data_d;
            cnt_q   <= cnt_d;
            dir_q   <= dir_d;
        end
    end

    assign in_ready  = (state_q == IDLE);
    assign out_valid = (state_q == DONE);
    assign out_data  = (state_q == DONE) ? data_q : '0;
    assign busy      = (state_q != IDLE);

endmodule
`default_nettype wire
